solver_sample_reader: RTL and testbench
=======================================

# solver_sample_reader

Captures the IEEE-754 single-precision current and speed outputs of the floating-point motor-model solver on its update strobe. Samples are decimated, converted to saturated signed fixed point, and buffered in a small FIFO. A valid/ready stream drains the FIFO to the capture/DMA logic. The block is the consumer end of the solver's i/w output interface.

## Interface

Parameters:
- FRAC_BITS, 16: fractional bits of the signed 32-bit fixed-point output. Legal range 0..30.
- DECIM, 1: keep one sample every DECIM strobes. Legal range 1..65535.
- DEPTH, 16: FIFO depth in sample pairs. Must be a power of two, 2..256.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: capture enable.
- sample_stb, input, 1: solver update strobe. i_fp and w_fp are valid in the cycle it is high.
- i_fp, input, 32: solver current, IEEE-754 single.
- w_fp, input, 32: solver speed, IEEE-754 single.
- m_data, output, 64: {i_fx[31:0], w_fx[31:0]} from the FIFO head.
- m_valid, output, 1: FIFO not empty.
- m_ready, input, 1: consumer accepts m_data.
- level, output, $clog2(DEPTH)+1: FIFO occupancy.
- overflow, output, 1: sticky flag, set when a sample is dropped.
- clr_ovf, input, 1: synchronous clear of overflow.
- seq, output, 16: count of samples pushed into the FIFO. Wraps from 0xFFFF to 0.

## Operation

Decimation:
- A counter dcnt runs 0..DECIM-1 and advances on each sample_stb while en=1.
- A capture occurs when sample_stb=1, en=1 and dcnt==0.
- en=0 forces dcnt to 0. The first strobe after enable is therefore captured.

Stage 1 (capture):
- On a capture, i_fp and w_fp are registered into a stage register and stage_vld is set for one cycle.

Stage 2 (convert and push):
- Both stage words are converted combinationally and pushed into the FIFO at the end of the cycle in which stage_vld=1.

Conversion, per word: s = bit 31, e = bits 30:23, mant = {1, bits 22:0}, sh = e - 127 + FRAC_BITS - 23.
- e==0 (zero or denormal): result is 0.
- e==255 with a nonzero fraction (NaN): result is 0.
- e==255 with a zero fraction (infinity): saturate.
- sh >= 0: mag = mant << sh. If mag > 0x7FFFFFFF (including any bits shifted out), saturate.
- sh < 0: mag = mant >> -sh, truncated toward zero. If sh <= -24, mag = 0.
- Apply the sign by two's complement. A negative result of zero gives 0.
- Saturation gives 0x7FFFFFFF for positive inputs and 0x80000001 for negative inputs (symmetric).

FIFO:
- A pop occurs when m_valid && m_ready.
- A push occurs when stage_vld=1.
  - If the FIFO is full and no pop occurs in that cycle, the sample is dropped, overflow is set, and seq does not increment.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Each accepted push increments seq.
- Simultaneous push and pop leaves level unchanged.
- Read and write pointers wrap modulo DEPTH.

Overflow flag:
- clr_ovf clears overflow.
- If clr_ovf and a drop occur in the same cycle, overflow stays set (set wins).

## Timing

- Reset values: m_valid=0, m_data=0, level=0, overflow=0, seq=0, dcnt=0, stage_vld=0, FIFO pointers=0.
- Latency: capture strobe in cycle n, FIFO write at the end of n+1, m_valid=1 in cycle n+2 if the FIFO was empty.
- Sustained throughput is one sample per cycle. Strobes on consecutive cycles are all captured when DECIM=1.
- m_data is driven from the FIFO head, registered memory read or register file. It is stable while m_valid=1 and m_ready=0.
- m_valid never deasserts without a pop.
- Reset mid-operation: all state returns to the reset values immediately. Any stage or FIFO contents are discarded.
- Changing en affects only captures. Samples already in stage 1 or the FIFO are still delivered.

## Test plan

- FRAC_BITS=16, DECIM=1, one strobe with i_fp=0x3F800000 (1.0) and w_fp=0xC0200000 (-2.5) -> m_valid rises 2 cycles later with m_data=0x00010000_FFFD8000; seq=1 after the push.
- Conversion edges with FRAC_BITS=16 -> 0x49742400 (1e6) gives 0x7FFFFFFF; 0xC9742400 gives 0x80000001; 0x358637BD (1e-6) gives 0; 0x7FC00000 (NaN) gives 0; 0x00000001 (denormal) gives 0; 0x3F000001 gives 0x00008000.
- DECIM=4, en=1, 8 strobes with distinct values -> exactly 2 entries (strobes 1 and 5) in order; deassert en, reassert, one strobe -> captured immediately.
- DEPTH=8, m_ready=0, 10 strobes -> level=8, overflow=1, seq=8; then m_ready=1 -> 8 pops of the first 8 samples in order, m_valid=0, level=0; clr_ovf -> overflow=0.
- FIFO full, with a strobe timed so its push lands in the same cycle as a pop -> push accepted, level stays 8, overflow stays 0.
- Assert rst_n low with 3 entries queued and stage_vld=1 -> all outputs return to their reset values immediately; no data appears after release until a new strobe.

Source files
------------

// File: rtl/solver_sample_reader.sv
// solver_sample_reader
// Consumer end of the motor-model solver's i/w output. Decimates the solver
// update strobe, converts the IEEE-754 single current and speed words to
// saturated signed 32-bit fixed point, and queues the pairs in a small FIFO.
// The FIFO drains over a valid/ready stream.
module solver_sample_reader #(
    parameter int FRAC_BITS = 16,
    parameter int DECIM     = 1,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sample_stb,
    input  logic [31:0]            i_fp,
    input  logic [31:0]            w_fp,
    output logic [63:0]            m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [15:0]            seq
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              LW         = AW + 1;
    localparam logic [15:0]     DCNT_LAST  = 16'(DECIM - 1);
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
    localparam logic [31:0]     SAT_POS    = 32'h7FFF_FFFF;
    localparam logic [31:0]     SAT_NEG    = 32'h8000_0001;

    // Float to saturated fixed point. A shift of 8 or more always pushes the
    // hidden bit past bit 30, so that is the saturation threshold; smaller
    // left shifts always fit in 31 bits.
    function automatic logic [31:0] fp_to_fx(input logic [31:0] f);
        logic        sgn;
        logic [7:0]  expo;
        logic [31:0] mant;
        logic [31:0] mag;
        logic        sat;
        int          sh;
        sgn  = f[31];
        expo = f[30:23];
        mant = {8'd0, 1'b1, f[22:0]};
        sh   = int'({24'd0, expo}) - 150 + FRAC_BITS;
        mag  = '0;
        sat  = 1'b0;
        if (expo == 8'd0) begin
            mag = '0;
        end else if (expo == 8'hFF) begin
            sat = (f[22:0] == 23'd0);
        end else if (sh >= 8) begin
            sat = 1'b1;
        end else if (sh >= 0) begin
            mag = mant << sh;
        end else if (sh > -24) begin
            mag = mant >> (-sh);
        end
        if (sat) begin
            return sgn ? SAT_NEG : SAT_POS;
        end
        return sgn ? (~mag + 32'd1) : mag;
    endfunction

    logic [15:0]   dcnt_reg;
    logic          capture;
    logic          stage_vld_reg;
    logic [63:0]   in_pair;
    logic [63:0]   push_data;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic          overflow_reg;
    logic [15:0]   seq_reg;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign capture = sample_stb & en & (dcnt_reg == 16'd0);

    // Decimation counter: free-runs over strobes while enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_reg <= '0;
        end else if (!en) begin
            dcnt_reg <= '0;
        end else if (sample_stb) begin
            dcnt_reg <= (dcnt_reg == DCNT_LAST) ? 16'd0 : dcnt_reg + 16'd1;
        end
    end

    // Stage-1 valid: one-cycle pulse following each capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_reg <= 1'b0;
        end else begin
            stage_vld_reg <= capture;
        end
    end

    // Lane 0 carries current (upper half), lane 1 carries speed (lower half)
    assign in_pair = {i_fp, w_fp};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [31:0] word_reg;

        // Stage-1 word register for this lane, loaded on capture
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (capture) begin
                word_reg <= in_pair[63-32*gi -: 32];
            end
        end

        assign push_data[63-32*gi -: 32] = fp_to_fx(word_reg);
    end

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LEVEL);
    assign pop     = ~empty & m_ready;
    assign push_ok = stage_vld_reg & (~full | pop);
    assign drop    = stage_vld_reg & full & ~pop;

    // FIFO storage; a push into a full FIFO with a pop overwrites the slot being vacated
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Occupancy bookkeeping for push/pop combinations
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Pointers, level, sample counter; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            seq_reg    <= '0;
        end else begin
            level_reg <= level_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                seq_reg    <= seq_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    // Head word is gated so the stream shows zero whenever nothing is queued
    assign m_data   = empty ? 64'd0 : mem[rd_ptr_reg];
    assign m_valid  = ~empty;
    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign seq      = seq_reg;

endmodule

// File: tb/tb_solver_sample_reader.sv
// Testbench for solver_sample_reader: two instances (DECIM=1 and DECIM=4,
// DEPTH=8) share stimulus; each is compared every cycle against a queue-based
// reference model whose conversion uses real arithmetic.
module tb_solver_sample_reader;

    localparam int FRAC  = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sample_stb = 1'b0;
    logic        m_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] i_fp = '0;
    logic [31:0] w_fp = '0;

    logic [63:0] m_data_w   [2];
    logic        m_valid_w  [2];
    logic [3:0]  level_w    [2];
    logic        overflow_w [2];
    logic [15:0] seq_w      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference conversion: value = 1.mant * 2^(e-127) * 2^FRAC, truncated toward zero
    function automatic logic [31:0] ref_fx(input logic [31:0] f);
        int          e;
        real         v;
        logic [31:0] mag;
        e = int'(f[30:23]);
        if (e == 0) return 32'd0;
        if (e == 255) begin
            if (f[22:0] != 23'd0) return 32'd0;
            return f[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end
        v = real'({1'b1, f[22:0]}) * (2.0 ** real'(e - 150 + FRAC));
        if (v >= 2147483648.0) return f[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
        mag = $rtoi(v);
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] pw(input int k, input logic neg);
        return {neg, 8'(127 + k), 23'd0};
    endfunction

    function automatic logic [63:0] expv(input int k);
        logic [31:0] p;
        p = 32'd1 << (16 + k);
        return {p, -p};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] frac;
        int          r;
        r    = $urandom_range(0, 9);
        frac = 23'($urandom);
        if (r == 0)      e = 8'd0;
        else if (r == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) frac = '0;
        end else         e = 8'($urandom_range(100, 165));
        return {1'($urandom), e, frac};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int DEC = (gi == 0) ? 1 : 4;

        solver_sample_reader #(
            .FRAC_BITS(FRAC),
            .DECIM    (DEC),
            .DEPTH    (DEPTH)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .sample_stb(sample_stb),
            .i_fp      (i_fp),
            .w_fp      (w_fp),
            .m_data    (m_data_w[gi]),
            .m_valid   (m_valid_w[gi]),
            .m_ready   (m_ready),
            .level     (level_w[gi]),
            .overflow  (overflow_w[gi]),
            .clr_ovf   (clr_ovf),
            .seq       (seq_w[gi])
        );

        int          dcnt_m = 0;
        bit          stg_v_m = 0;
        logic [63:0] stg_d_m = '0;
        logic [63:0] q [$];
        bit          ovf_m = 0;
        logic [15:0] seq_m = '0;
        int          pops = 0;

        // Reference model: one step per clock, cleared asynchronously by reset
        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    dcnt_m  = 0;
                    stg_v_m = 0;
                    q.delete();
                    ovf_m   = 0;
                    seq_m   = '0;
                end else begin
                    bit pop_m;
                    bit drop_m;
                    pop_m  = (q.size() != 0) && m_ready;
                    drop_m = 0;
                    if (pop_m) begin
                        $display("[dut%0d] pop %0d data=%h", gi, pops, q[0]);
                        pops++;
                        void'(q.pop_front());
                    end
                    if (stg_v_m) begin
                        if (q.size() < DEPTH) begin
                            q.push_back(stg_d_m);
                            seq_m = seq_m + 16'd1;
                        end else begin
                            drop_m = 1;
                        end
                    end
                    if (drop_m) ovf_m = 1;
                    else if (clr_ovf) ovf_m = 0;
                    stg_v_m = en && sample_stb && (dcnt_m == 0);
                    if (stg_v_m) stg_d_m = {ref_fx(i_fp), ref_fx(w_fp)};
                    if (!en) dcnt_m = 0;
                    else if (sample_stb) dcnt_m = (dcnt_m + 1) % DEC;
                end
            end
        end

        // Per-cycle comparison of all observable outputs against the model
        initial begin
            forever begin
                @(negedge clk);
                check_value($sformatf("d%0d_valid", gi), 64'(m_valid_w[gi]), 64'(q.size() != 0));
                check_value($sformatf("d%0d_level", gi), 64'(level_w[gi]), 64'(q.size()));
                check_value($sformatf("d%0d_ovf", gi), 64'(overflow_w[gi]), 64'(ovf_m));
                check_value($sformatf("d%0d_seq", gi), 64'(seq_w[gi]), 64'(seq_m));
                if (q.size() != 0)
                    check_value($sformatf("d%0d_data", gi), m_data_w[gi], q[0]);
                else if (!rst_n)
                    check_value($sformatf("d%0d_rst_data", gi), m_data_w[gi], 64'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        sample_stb = 0; m_ready = 0; clr_ovf = 0; en = 0;
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        en = 1;
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] b);
        i_fp = a; w_fp = b; sample_stb = 1;
        @(negedge clk);
        sample_stb = 0;
    endtask

    logic [31:0] edge_i [3];
    logic [31:0] edge_w [3];
    logic [63:0] edge_x [3];

    initial begin
        edge_i[0] = 32'h4974_2400; edge_w[0] = 32'hC974_2400; edge_x[0] = 64'h7FFFFFFF_80000001;
        edge_i[1] = 32'h3586_37BD; edge_w[1] = 32'h7FC0_0000; edge_x[1] = 64'h00000000_00000000;
        edge_i[2] = 32'h0000_0001; edge_w[2] = 32'h3F00_0001; edge_x[2] = 64'h00000000_00008000;

        // Reset state
        @(negedge clk);
        check_value("rst_valid", 64'(m_valid_w[0]), 64'd0);
        check_value("rst_data", m_data_w[0], 64'd0);
        check_value("rst_level", 64'(level_w[0]), 64'd0);
        check_value("rst_ovf", 64'(overflow_w[0]), 64'd0);
        check_value("rst_seq", 64'(seq_w[0]), 64'd0);
        rst_n = 1;
        en = 1;

        // Basic conversion and latency
        strobe(32'h3F80_0000, 32'hC020_0000);
        check_value("lat_valid_early", 64'(m_valid_w[0]), 64'd0);
        @(negedge clk);
        check_value("lat_valid", 64'(m_valid_w[0]), 64'd1);
        check_value("basic_data", m_data_w[0], 64'h00010000_FFFD8000);
        check_value("basic_seq", 64'(seq_w[0]), 64'd1);
        m_ready = 1; @(negedge clk); m_ready = 0;

        // Conversion edges
        for (int k = 0; k < 3; k++) begin
            en = 0; @(negedge clk); en = 1;
            strobe(edge_i[k], edge_w[k]);
            @(negedge clk);
            check_value($sformatf("edge%0d_d0", k), m_data_w[0], edge_x[k]);
            check_value($sformatf("edge%0d_d1", k), m_data_w[1], edge_x[k]);
            m_ready = 1; @(negedge clk); m_ready = 0;
        end

        // Decimation
        do_reset();
        for (int k = 0; k < 8; k++) begin
            i_fp = pw(k, 0); w_fp = pw(k, 1); sample_stb = 1;
            @(negedge clk);
        end
        sample_stb = 0;
        repeat (2) @(negedge clk);
        check_value("dec_level_d1", 64'(level_w[1]), 64'd2);
        check_value("dec_level_d0", 64'(level_w[0]), 64'd8);
        check_value("dec_head0", m_data_w[1], expv(0));
        m_ready = 1; @(negedge clk); m_ready = 0;
        check_value("dec_head1", m_data_w[1], expv(4));
        m_ready = 1; repeat (10) @(negedge clk); m_ready = 0;
        check_value("dec_drained", 64'(m_valid_w[1]), 64'd0);
        strobe(pw(1, 0), pw(1, 1));
        strobe(pw(2, 0), pw(2, 1));
        en = 0; @(negedge clk); en = 1;
        strobe(pw(3, 0), pw(3, 1));
        @(negedge clk);
        check_value("reen_level", 64'(level_w[1]), 64'd2);
        check_value("reen_head0", m_data_w[1], expv(1));
        m_ready = 1; @(negedge clk); m_ready = 0;
        check_value("reen_head1", m_data_w[1], expv(3));

        // Overflow
        do_reset();
        for (int k = 0; k < 10; k++) begin
            i_fp = pw(k, 0); w_fp = pw(k, 1); sample_stb = 1;
            @(negedge clk);
        end
        sample_stb = 0;
        repeat (2) @(negedge clk);
        check_value("ovf_level", 64'(level_w[0]), 64'd8);
        check_value("ovf_flag", 64'(overflow_w[0]), 64'd1);
        check_value("ovf_seq", 64'(seq_w[0]), 64'd8);
        m_ready = 1;
        for (int k = 0; k < 8; k++) begin
            check_value($sformatf("ovf_pop%0d", k), m_data_w[0], expv(k));
            @(negedge clk);
        end
        m_ready = 0;
        check_value("ovf_empty", 64'(m_valid_w[0]), 64'd0);
        check_value("ovf_level0", 64'(level_w[0]), 64'd0);
        clr_ovf = 1; @(negedge clk); clr_ovf = 0;
        check_value("ovf_clr", 64'(overflow_w[0]), 64'd0);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int k = 0; k < 8; k++) begin
            i_fp = pw(k, 0); w_fp = pw(k, 1); sample_stb = 1;
            @(negedge clk);
        end
        sample_stb = 0;
        repeat (2) @(negedge clk);
        check_value("full_level", 64'(level_w[0]), 64'd8);
        strobe(pw(9, 0), pw(9, 1));
        m_ready = 1; @(negedge clk); m_ready = 0;
        check_value("fullpop_level", 64'(level_w[0]), 64'd8);
        check_value("fullpop_ovf", 64'(overflow_w[0]), 64'd0);
        check_value("fullpop_seq", 64'(seq_w[0]), 64'd9);
        check_value("fullpop_head", m_data_w[0], expv(1));

        // Reset mid-operation
        do_reset();
        for (int k = 0; k < 3; k++) strobe(pw(k, 0), pw(k, 1));
        @(negedge clk);
        strobe(pw(5, 0), pw(5, 1));
        #2 rst_n = 0;
        #1;
        check_value("mid_rst_valid", 64'(m_valid_w[0]), 64'd0);
        check_value("mid_rst_level", 64'(level_w[0]), 64'd0);
        check_value("mid_rst_data", m_data_w[0], 64'd0);
        check_value("mid_rst_seq", 64'(seq_w[0]), 64'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check_value("post_rst_valid", 64'(m_valid_w[0]), 64'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            en         = ($urandom_range(0, 9) != 0);
            sample_stb = 1'($urandom_range(0, 1));
            if (((c / 200) % 2) == 1) m_ready = ($urandom_range(0, 3) == 0);
            else                      m_ready = ($urandom_range(0, 3) != 0);
            clr_ovf    = ($urandom_range(0, 15) == 0);
            i_fp       = rand_fp();
            w_fp       = rand_fp();
            @(negedge clk);
        end
        sample_stb = 0;
        m_ready = 1;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
